if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch unit: issues one instruction-memory read per controller request,
// registers the returned word (or a NOP on timeout), and pulses fetch_done once per fetch.
module if_fetch #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] pc,
    input  logic        fetch_req,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:2] ir_pc,
    output logic [31:2] pc_plus4,
    output logic        fetch_done,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0]  TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [29:0] RESET_PC   = 30'h0000_0C00;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  timer_reg;
    logic [29:0] addr_reg;
    logic [31:0] ir_reg;
    logic [29:0] ir_pc_reg;
    logic        done_reg;
    logic        err_reg;

    logic        start;
    logic        capture_data;
    logic        capture_nop;
    logic        timer_run;
    logic        expired;

    // Saturating compare keeps the abort condition true even if the timer overshoots.
    assign expired = (timer_reg >= TIMER_LAST);

    always_comb begin
        state_next   = state_reg;
        start        = 1'b0;
        capture_data = 1'b0;
        capture_nop  = 1'b0;
        timer_run    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fetch_req && !flush) begin
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                timer_run = 1'b1;
                if (flush) begin
                    // A grant in the flush cycle leaves a response in flight; drain it.
                    state_next = imem_gnt ? DRAIN : IDLE;
                end else if (imem_gnt) begin
                    state_next = WAIT;
                end else if (expired) begin
                    capture_nop = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT: begin
                timer_run = 1'b1;
                if (imem_rvalid) begin
                    capture_data = !flush;
                    state_next   = IDLE;
                end else if (flush) begin
                    state_next = DRAIN;
                end else if (expired) begin
                    capture_nop = 1'b1;
                    state_next  = IDLE;
                end
            end
            DRAIN: begin
                timer_run = 1'b1;
                if (imem_rvalid || expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= 8'd0;
            addr_reg  <= 30'd0;
            ir_reg    <= 32'h0000_0000;
            ir_pc_reg <= RESET_PC;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= capture_data | capture_nop;

            if (start) begin
                timer_reg <= 8'd0;
            end else if (timer_run && (timer_reg != 8'hFF)) begin
                timer_reg <= timer_reg + 8'd1;
            end

            if (start) begin
                addr_reg <= pc;
            end

            if (capture_data) begin
                ir_reg <= imem_rdata;
            end else if (capture_nop) begin
                ir_reg <= NOP_WORD;
            end

            if (capture_data || capture_nop) begin
                ir_pc_reg <= addr_reg;
            end

            if (start) begin
                err_reg <= 1'b0;
            end else if (capture_nop) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign imem_req   = (state_reg == REQ);
    assign imem_addr  = addr_reg;
    assign ir         = ir_reg;
    assign ir_pc      = ir_pc_reg;
    assign pc_plus4   = ir_pc_reg + 30'd1;
    assign fetch_done = done_reg;
    assign busy       = (state_reg != IDLE);
    assign err        = err_reg;

endmodule
